// File: rtl/simd_job_arbiter_pkg.sv
// Shared types and constants for the SIMD job arbiter: FSM encoding, default
// field widths and the opcode values core control also decodes.
package simd_job_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam int INSTR_W_DEF = 3;
    localparam int SIZE_W_DEF  = 6;

    localparam logic [INSTR_W_DEF-1:0] OP_NOP = 3'd0;
    localparam logic [INSTR_W_DEF-1:0] OP_ADD = 3'd1;
    localparam logic [INSTR_W_DEF-1:0] OP_SUB = 3'd2;
    localparam logic [INSTR_W_DEF-1:0] OP_MUL = 3'd3;
    localparam logic [INSTR_W_DEF-1:0] OP_MAC = 3'd4;

    // Counter width for a terminal count of n-1; never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/simd_job_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not win last time. Purely combinational.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
        grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);
    end

endmodule

// File: rtl/simd_job_arbiter.sv
// Shares one SIMD unit between two command ports: arbitrates, issues one job,
// waits for done or timeout, then emits a tagged one-cycle response.
module simd_job_arbiter
    import simd_job_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INSTR_W        = INSTR_W_DEF,
    parameter int SIZE_W         = SIZE_W_DEF
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req0_valid_i,
    input  logic [INSTR_W-1:0] req0_instruction_i,
    input  logic [SIZE_W-1:0]  req0_data_size_i,
    output logic               req0_ready_o,
    input  logic               req1_valid_i,
    input  logic [INSTR_W-1:0] req1_instruction_i,
    input  logic [SIZE_W-1:0]  req1_data_size_i,
    output logic               req1_ready_o,
    output logic               simd_valid_instruction_o,
    output logic [INSTR_W-1:0] simd_instruction_o,
    output logic [SIZE_W-1:0]  simd_data_size_o,
    output logic               simd_valid_data_o,
    input  logic               simd_done_i,
    output logic               rsp_valid_o,
    output logic               rsp_id_o,
    output logic               rsp_timeout_o,
    output logic               busy_o,
    output logic [15:0]        job_count_o
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [SIZE_W-1:0]  size_q, size_d;
    logic               id_q, id_d;
    logic               to_q, to_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        job_q, job_d;
    logic [1:0]         grant;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid_i, req0_valid_i}),
        .last_grant_i (last_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        size_d  = size_q;
        id_d    = id_q;
        to_d    = to_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        job_d   = job_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    id_d    = grant[1];
                    instr_d = grant[1] ? req1_instruction_i : req0_instruction_i;
                    size_d  = grant[1] ? req1_data_size_i : req0_data_size_i;
                    to_d    = 1'b0;
                    // Empty jobs never touch the SIMD unit.
                    state_d = (size_d == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (simd_done_i) begin
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = id_q;
                job_d   = job_q + 16'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            size_q  <= '0;
            id_q    <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            job_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            size_q  <= size_d;
            id_q    <= id_d;
            to_q    <= to_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            job_q   <= job_d;
        end
    end

    assign req0_ready_o             = (state_q == ST_IDLE) && grant[0];
    assign req1_ready_o             = (state_q == ST_IDLE) && grant[1];
    assign simd_valid_instruction_o = (state_q == ST_ISSUE);
    assign simd_valid_data_o        = (state_q == ST_RUN);
    assign simd_instruction_o       = instr_q;
    assign simd_data_size_o         = size_q;
    assign rsp_valid_o              = (state_q == ST_RESP);
    assign rsp_id_o                 = id_q;
    assign rsp_timeout_o            = to_q;
    assign busy_o                   = (state_q != ST_IDLE);
    assign job_count_o              = job_q;

endmodule

// File: tb/tb_simd_job_arbiter.sv
// Bench for simd_job_arbiter: directed scenarios plus randomized jobs checked
// against a timing model derived from the arbitration and latency rules.
module tb_simd_job_arbiter;

    localparam int T = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [2:0] req0_instruction, req1_instruction;
    logic [5:0] req0_data_size, req1_data_size;
    logic       req0_ready, req1_ready;
    logic       simd_valid_instruction, simd_valid_data, simd_done;
    logic [2:0] simd_instruction;
    logic [5:0] simd_data_size;
    logic       rsp_valid, rsp_id, rsp_timeout, busy;
    logic [15:0] job_count;

    int errors = 0;
    int checks = 0;
    int exp_last;
    int exp_count;

    simd_job_arbiter #(.TIMEOUT_CYCLES(T), .INSTR_W(3), .SIZE_W(6)) dut (
        .clk_i                    (clk),
        .reset_i                  (reset),
        .req0_valid_i             (req0_valid),
        .req0_instruction_i       (req0_instruction),
        .req0_data_size_i         (req0_data_size),
        .req0_ready_o             (req0_ready),
        .req1_valid_i             (req1_valid),
        .req1_instruction_i       (req1_instruction),
        .req1_data_size_i         (req1_data_size),
        .req1_ready_o             (req1_ready),
        .simd_valid_instruction_o (simd_valid_instruction),
        .simd_instruction_o       (simd_instruction),
        .simd_data_size_o         (simd_data_size),
        .simd_valid_data_o        (simd_valid_data),
        .simd_done_i              (simd_done),
        .rsp_valid_o              (rsp_valid),
        .rsp_id_o                 (rsp_id),
        .rsp_timeout_o            (rsp_timeout),
        .busy_o                   (busy),
        .job_count_o              (job_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_last  = 1;
        exp_count = 0;
    endtask

    // Model: offsets are cycles after the accept cycle t.
    task automatic predict(input bit v0, input bit v1, input int size, input int done_at,
                           output int egid, output int erlat, output bit erto, output int eiss);
        if (v0 && v1) egid = (exp_last == 1) ? 0 : 1;
        else          egid = v0 ? 0 : 1;
        if (size == 0) begin
            erlat = 1; erto = 1'b0; eiss = 0;
        end else if (done_at >= 2 && done_at <= T + 1) begin
            erlat = done_at + 1; erto = 1'b0; eiss = 1;
        end else begin
            erlat = T + 2; erto = 1'b1; eiss = 1;
        end
        exp_last  = egid;
        exp_count = (exp_count + 1) % 65536;
    endtask

    // Presents a job in an IDLE cycle, pulses simd_done at offset done_at, and
    // returns what was observed; ends in the IDLE cycle after the response.
    task automatic do_job(input bit v0, input bit v1, input logic [2:0] i0, input logic [2:0] i1,
                          input logic [5:0] s0, input logic [5:0] s1, input int done_at,
                          output int gid, output bit two_rdy, output int rlat, output bit rid,
                          output bit rto, output int issues, output int ilat, output int vd,
                          output logic [2:0] iins, output logic [5:0] isz, output int busy_rdy);
        req0_valid = v0; req0_instruction = i0; req0_data_size = s0;
        req1_valid = v1; req1_instruction = i1; req1_data_size = s1;
        #1;
        two_rdy = req0_ready & req1_ready;
        gid = req1_ready ? 1 : (req0_ready ? 0 : -1);
        tick();
        rlat = -1; rid = 1'b0; rto = 1'b0; issues = 0; ilat = -1; vd = 0; busy_rdy = 0;
        iins = '0; isz = '0;
        for (int n = 1; n <= T + 20; n++) begin
            if (simd_valid_instruction) begin
                issues++; ilat = n; iins = simd_instruction; isz = simd_data_size;
            end
            if (simd_valid_data) vd++;
            if (req0_ready || req1_ready) busy_rdy++;
            if (rsp_valid) begin
                rlat = n; rid = rsp_id; rto = rsp_timeout;
                break;
            end
            simd_done = (n == done_at);
            tick();
        end
        simd_done = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (job_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", job_count); end
        checks++; if ({rsp_valid, simd_valid_instruction, simd_valid_data} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {rsp_valid, simd_valid_instruction, simd_valid_data}); end
        checks++; if ({simd_instruction, simd_data_size} !== 9'd0) begin errors++; $display("FAIL reset_fields: got %0h want 0", {simd_instruction, simd_data_size}); end
        checks++; if ({rsp_id, rsp_timeout, req0_ready, req1_ready} !== 4'b0000) begin errors++; $display("FAIL reset_rsp_rdy: got %b want 0000", {rsp_id, rsp_timeout, req0_ready, req1_ready}); end
    endtask

    task automatic test_single();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        do_job(1, 0, 3'd3, 3'd0, 6'd4, 6'd0, 6, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
        checks++; if (gid !== 0) begin errors++; $display("FAIL single_grant: got %0d want 0", gid); end
        checks++; if (ilat !== 1 || iss !== 1) begin errors++; $display("FAIL single_issue: got lat %0d n %0d want 1 1", ilat, iss); end
        checks++; if (ii !== 3'd3 || is !== 6'd4) begin errors++; $display("FAIL single_fields: got %0d/%0d want 3/4", ii, is); end
        checks++; if (rlat !== 7 || rid !== 1'b0 || rto !== 1'b0) begin errors++; $display("FAIL single_rsp: got lat %0d id %0b to %0b want 7 0 0", rlat, rid, rto); end
        checks++; if (vd !== 5) begin errors++; $display("FAIL single_valid_data: got %0d want 5", vd); end
        checks++; if (job_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", job_count); end
    endtask

    task automatic test_round_robin();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        int want[4] = '{0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            do_job(1, 1, 3'd1, 3'd2, 6'd7, 6'd9, 3, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
            checks++; if (gid !== want[k] || rid !== want[k][0]) begin errors++; $display("FAIL rr_grant%0d: got %0d id %0b want %0d", k, gid, rid, want[k]); end
            checks++; if (two || br != 0) begin errors++; $display("FAIL rr_ready_excl%0d: got both %0b busy %0d want 0 0", k, two, br); end
            checks++; if (rlat !== 4) begin errors++; $display("FAIL rr_lat%0d: got %0d want 4", k, rlat); end
        end
    endtask

    task automatic test_timeout();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        do_job(0, 1, 3'd0, 3'd5, 6'd0, 6'd12, -1, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
        checks++; if (rlat !== T + 2 || rid !== 1'b1 || rto !== 1'b1) begin errors++; $display("FAIL timeout_rsp: got lat %0d id %0b to %0b want %0d 1 1", rlat, rid, rto, T + 2); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy %0b want 0", busy); end
    endtask

    task automatic test_done_vs_terminal();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        logic [15:0] cnt;
        int strays;
        do_job(1, 0, 3'd2, 3'd0, 6'd1, 6'd0, T + 1, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
        checks++; if (rlat !== T + 2 || rto !== 1'b0) begin errors++; $display("FAIL terminal_done: got lat %0d to %0b want %0d 0", rlat, rto, T + 2); end
        cnt = job_count;
        strays = 0;
        simd_done = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (rsp_valid || busy) strays++;
        end
        simd_done = 1'b0;
        tick();
        checks++; if (strays != 0 || job_count !== cnt) begin errors++; $display("FAIL stray_done: got %0d events count %0d want 0 events count %0d", strays, job_count, cnt); end
    endtask

    task automatic test_zero_size();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        do_job(1, 0, 3'd4, 3'd0, 6'd0, 6'd0, 1, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
        checks++; if (gid !== 0 || rlat !== 1 || rto !== 1'b0) begin errors++; $display("FAIL zero_rsp: got grant %0d lat %0d to %0b want 0 1 0", gid, rlat, rto); end
        checks++; if (iss != 0 || vd != 0) begin errors++; $display("FAIL zero_no_issue: got issue %0d data %0d want 0 0", iss, vd); end
    endtask

    task automatic test_reset_in_run();
        int ev;
        req0_valid = 1'b1; req0_instruction = 3'd6; req0_data_size = 6'd5;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b1 || simd_valid_data !== 1'b1) begin errors++; $display("FAIL run_before_reset: got busy %0b vd %0b want 1 1", busy, simd_valid_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_last = 1; exp_count = 0;
        ev = (busy | rsp_valid | simd_valid_data) ? 1 : 0;
        checks++; if (ev != 0 || job_count !== 16'd0) begin errors++; $display("FAIL reset_in_run: got events %0d count %0d want 0 0", ev, job_count); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_no_rsp: got rsp %0b busy %0b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_count_wrap();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        force dut.job_q = 16'hFFFF;
        tick();
        release dut.job_q;
        tick();
        checks++; if (job_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h want ffff", job_count); end
        do_job(0, 1, 3'd0, 3'd1, 6'd0, 6'd3, 4, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
        exp_last = 1; exp_count = 0;
        checks++; if (job_count !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %0h want 0", job_count); end
    endtask

    task automatic test_random();
        int gid, rlat, iss, ilat, vd, br; bit two, rid, rto; logic [2:0] ii; logic [5:0] is;
        int egid, erlat, eiss, dat;
        bit erto, v0, v1;
        logic [2:0] i0, i1; logic [5:0] s0, s1, es;
        for (int k = 0; k < 24; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            i0 = 3'($urandom); i1 = 3'($urandom);
            s0 = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            s1 = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            dat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T + 4));
            predict(v0, v1, (v0 && v1) ? ((exp_last == 1) ? int'(s0) : int'(s1)) : (v0 ? int'(s0) : int'(s1)),
                    dat, egid, erlat, erto, eiss);
            es = (egid == 0) ? s0 : s1;
            do_job(v0, v1, i0, i1, s0, s1, dat, gid, two, rlat, rid, rto, iss, ilat, vd, ii, is, br);
            checks++;
            if (gid !== egid || rid !== egid[0] || rlat !== erlat || rto !== erto || iss !== eiss
                || job_count !== 16'(exp_count) || two || br != 0
                || (eiss == 1 && (ii !== ((egid == 0) ? i0 : i1) || is !== es))) begin
                errors++;
                $display("FAIL rand%0d: got g%0d lat%0d to%0b iss%0d cnt%0d want g%0d lat%0d to%0b iss%0d cnt%0d",
                         k, gid, rlat, rto, iss, job_count, egid, erlat, erto, eiss, exp_count);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; simd_done = 1'b0;
        req0_instruction = '0; req1_instruction = '0;
        req0_data_size = '0; req1_data_size = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_done_vs_terminal();
        test_zero_size();
        test_reset_in_run();
        test_count_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
